hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline control unit for the 5-stage core. It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves, by priority, data-cache miss freezes, branch mispredict recovery, load-use stalls and instruction-fetch waits. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
REG_ADDR_W, 5, register index width
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  ID-stage source register 1
id_rs2  in  REG_ADDR_W  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  EX-stage instruction is a load
ex_rd  in  REG_ADDR_W  EX-stage destination register
ex_mispredict  in  1  EX branch resolved opposite to prediction (or wrong target)
mem_access  in  1  MEM stage holds a load/store this cycle
dcache_miss  in  1  qualifies mem_access: access missed
dcache_ack  in  1  one-cycle pulse: refill done, data valid
icache_ready  in  1  fetched instruction valid this cycle
pc_write  out  1  PC register update enable
ifid_write  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID synchronous clear (priority over write)
idex_write  out  1  ID/EX write enable
idex_flush  out  1  ID/EX clear
exmem_write  out  1  EX/MEM write enable
ctrl_state  out  2  FSM state: 0 RUN, 1 DWAIT
stall_cnt  out  CNT_WIDTH  cycles with pc_write=0
flush_cnt  out  CNT_WIDTH  mispredict recoveries
loaduse_cnt  out  CNT_WIDTH  load-use bubbles inserted

Behaviour:
- Reset (rstn=0, async): state=RUN, all counters=0. Control outputs are combinational from state and inputs. During reset, force pc_write=ifid_write=idex_write=exmem_write=0 and ifid_flush=idex_flush=1.
- freeze = (state==DWAIT) or (state==RUN and mem_access and dcache_miss).
- loaduse = ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
- Control output priority, evaluated each cycle; the first matching case wins:
  1. freeze: all four write enables 0, both flushes 0. The whole pipeline holds, and an asserted ex_mispredict is held too.
  2. ex_mispredict: pc_write=1 (redirect), ifid_flush=1, idex_flush=1, ifid_write=1, idex_write=1, exmem_write=1.
  3. loaduse: pc_write=0, ifid_write=0, idex_flush=1 (bubble), idex_write=1, exmem_write=1, ifid_flush=0.
  4. !icache_ready: pc_write=0, ifid_flush=1 (bubble into ID), ifid_write=1, idex_write=1, exmem_write=1.
  5. otherwise: all write enables 1, flushes 0.
- FSM transitions:
  - RUN -> DWAIT when mem_access and dcache_miss and !dcache_ack.
  - RUN stays RUN when miss and ack occur in the same cycle. Freeze lasts exactly that one cycle.
  - DWAIT -> RUN on dcache_ack. The ack cycle is still frozen; the pipeline advances the cycle after.
  - In DWAIT, mem_access and dcache_miss are ignored.
- Counters:
  - Update on clk rising edge.
  - Saturate at all-ones; no wrap.
  - stall_cnt +1 on each cycle with pc_write=0.
  - flush_cnt +1 on each cycle rule 2 fires.
  - loaduse_cnt +1 on each cycle rule 3 fires.
- Reset asserted mid-DWAIT returns to RUN immediately; any pending ack is discarded.
- No combinational path from any output back to an input.

Test Plan:
- Reset then idle: with icache_ready=1 and all else 0 -> pc_write=ifid_write=idex_write=exmem_write=1, flushes 0, counters stay 0 over 10 cycles.
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 -> pc_write=0, ifid_write=0, idex_flush=1; loaduse_cnt=1 and stall_cnt=1 next cycle. Repeat with ex_rd=0 -> no stall.
- Mispredict: ex_mispredict=1 for 1 cycle -> pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt increments to 1.
- Dcache miss: mem_access=dcache_miss=1 at cycle 0, dcache_ack at cycle 4 -> ctrl_state=1 for cycles 1-4, write enables 0 for cycles 0-4, stall_cnt=5, resume at cycle 5. Check the same-cycle miss+ack case freezes exactly 1 cycle.
- Priority: during DWAIT assert ex_mispredict and loaduse -> no flush, flush_cnt unchanged. After ack, with mispredict still high, the flush fires once.
- Saturation/reset: preload via CNT_WIDTH=3 build, 9 stall cycles -> stall_cnt holds 7. Drop rstn mid-DWAIT -> ctrl_state=0 and counters 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard inputs, stage control outputs and perf counters
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH = 32
);
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict;
    logic mem_access, dcache_miss, dcache_ack, icache_ready;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
    logic [1:0] ctrl_state;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt, loaduse_cnt;
    modport master (
        output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict,
        output mem_access, dcache_miss, dcache_ack, icache_ready,
        input pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
        input ctrl_state, stall_cnt, flush_cnt, loaduse_cnt
    );
    modport slave (
        input id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict,
        input mem_access, dcache_miss, dcache_ack, icache_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
        output ctrl_state, stall_cnt, flush_cnt, loaduse_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised freeze/redirect/stall/bubble control for a 5-stage pipeline
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH = 32
) (
    input logic clk,
    input logic rstn,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1} state_t;
    state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d, lu_q, lu_d;
    logic freeze, loaduse, mis_fire, lu_fire, ic_fire, pc_we;
    always_comb begin
        freeze = state_q == DWAIT || (bus.mem_access && bus.dcache_miss);
        loaduse = bus.ex_mem_read && bus.ex_rd != REG_ADDR_W'(0) &&
                  ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                   (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
        mis_fire = !freeze && bus.ex_mispredict;
        lu_fire = !freeze && !bus.ex_mispredict && loaduse;
        ic_fire = !freeze && !bus.ex_mispredict && !loaduse && !bus.icache_ready;
        pc_we = rstn && !freeze && !lu_fire && !ic_fire;
        state_d = state_q == RUN ? (bus.mem_access && bus.dcache_miss && !bus.dcache_ack ? DWAIT : RUN)
                                 : (bus.dcache_ack ? RUN : DWAIT);
        stall_d = stall_q + CNT_WIDTH'(!pc_we && !(&stall_q));
        flush_d = flush_q + CNT_WIDTH'(mis_fire && !(&flush_q));
        lu_d = lu_q + CNT_WIDTH'(lu_fire && !(&lu_q));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
            lu_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            lu_q <= lu_d;
        end
    end
    // reset forces every stage to hold with both flushes asserted
    assign bus.pc_write = pc_we;
    assign bus.ifid_write = rstn && !freeze && !lu_fire;
    assign bus.ifid_flush = !rstn || mis_fire || ic_fire;
    assign bus.idex_write = rstn && !freeze;
    assign bus.idex_flush = !rstn || mis_fire || lu_fire;
    assign bus.exmem_write = rstn && !freeze;
    assign bus.ctrl_state = state_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
    assign bus.loaduse_cnt = lu_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (32-bit and 3-bit counter builds)
module tb_hazard_ctrl;
    // control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write
    localparam logic [5:0] RUNV = 6'b110101, FRZ = 6'b000000, MIS = 6'b111111;
    localparam logic [5:0] LU = 6'b000111, IC = 6'b011101, RST = 6'b001010;
    typedef struct packed {
        logic ma, dm, ack, mis, icr;
        logic [2:0] lu;
        logic [7:0] exp;
    } cyc_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_WIDTH(32)) b32();
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_WIDTH(3)) b3();
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(b32.slave));
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_WIDTH(3)) dut3 (.clk(clk), .rstn(rstn), .bus(b3.slave));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    function automatic logic [7:0] obs();
        return {b32.pc_write, b32.ifid_write, b32.ifid_flush, b32.idex_write,
                b32.idex_flush, b32.exmem_write, b32.ctrl_state};
    endfunction
    // lu modes: 0 non-load rs2 match, 1 load rs2 hit, 2 load rs1 hit, 3 load to x0, 4 rs1 match unused
    task automatic apply(input cyc_t c);
        logic [4:0] rd, r1, r2;
        rd = (c.lu == 3'd2 || c.lu == 3'd4) ? 5'd7 : (c.lu == 3'd3 ? 5'd0 : 5'd5);
        r1 = (c.lu == 3'd2 || c.lu == 3'd4) ? 5'd7 : 5'd0;
        r2 = c.lu == 3'd4 ? 5'd3 : (c.lu == 3'd3 ? 5'd0 : 5'd5);
        b32.mem_access = c.ma; b3.mem_access = c.ma;
        b32.dcache_miss = c.dm; b3.dcache_miss = c.dm;
        b32.dcache_ack = c.ack; b3.dcache_ack = c.ack;
        b32.ex_mispredict = c.mis; b3.ex_mispredict = c.mis;
        b32.icache_ready = c.icr; b3.icache_ready = c.icr;
        b32.ex_mem_read = c.lu != 3'd0; b3.ex_mem_read = c.lu != 3'd0;
        b32.ex_rd = rd; b3.ex_rd = rd;
        b32.id_rs1 = r1; b3.id_rs1 = r1;
        b32.id_rs2 = r2; b3.id_rs2 = r2;
        b32.id_uses_rs1 = c.lu == 3'd2 || c.lu == 3'd3; b3.id_uses_rs1 = c.lu == 3'd2 || c.lu == 3'd3;
        b32.id_uses_rs2 = c.lu != 3'd2; b3.id_uses_rs2 = c.lu != 3'd2;
        exp_q.push_back(c.exp);
    endtask
    task automatic test_reset();
        apply({5'b00001, 3'd0, RST, 2'd0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", obs(), e); end
        @(negedge clk);
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== 96'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply({5'b00001, 3'd0, RUNV, 2'd0});
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL idle[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== 96'd0) begin
            failures++; $display("FAIL idle_cnt got=%0d/%0d/%0d exp=0/0/0", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
    endtask
    task automatic test_loaduse();
        cyc_t t [6] = '{{5'b00001, 3'd1, LU, 2'd0}, {5'b00001, 3'd3, RUNV, 2'd0},
                        {5'b00001, 3'd2, LU, 2'd0}, {5'b00001, 3'd4, RUNV, 2'd0},
                        {5'b00000, 3'd0, IC, 2'd0}, {5'b00001, 3'd0, RUNV, 2'd0}};
        foreach (t[i]) begin
            if (i == 1) begin
                checks++;
                if (b32.stall_cnt !== 32'd1 || b32.loaduse_cnt !== 32'd1) begin
                    failures++; $display("FAIL loaduse_first_cnt got stall=%0d lu=%0d exp 1/1", b32.stall_cnt, b32.loaduse_cnt);
                end
            end
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL loaduse[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== {32'd3, 32'd0, 32'd2}) begin
            failures++; $display("FAIL loaduse_cnt got=%0d/%0d/%0d exp=3/0/2", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
    endtask
    task automatic test_mispredict();
        cyc_t t [4] = '{{5'b00011, 3'd0, MIS, 2'd0}, {5'b00001, 3'd0, RUNV, 2'd0},
                        {5'b00011, 3'd1, MIS, 2'd0}, {5'b00001, 3'd0, RUNV, 2'd0}};
        foreach (t[i]) begin
            if (i == 1) begin
                checks++;
                if (b32.flush_cnt !== 32'd1) begin failures++; $display("FAIL mis_first_cnt got=%0d exp=1", b32.flush_cnt); end
            end
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL mispredict[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== {32'd3, 32'd2, 32'd2}) begin
            failures++; $display("FAIL mispredict_cnt got=%0d/%0d/%0d exp=3/2/2", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
    endtask
    task automatic test_dcache();
        cyc_t t [8] = '{{5'b11001, 3'd0, FRZ, 2'd0}, {5'b11001, 3'd0, FRZ, 2'd1},
                        {5'b11001, 3'd0, FRZ, 2'd1}, {5'b00001, 3'd0, FRZ, 2'd1},
                        {5'b00101, 3'd0, FRZ, 2'd1}, {5'b00001, 3'd0, RUNV, 2'd0},
                        {5'b11101, 3'd0, FRZ, 2'd0}, {5'b00001, 3'd0, RUNV, 2'd0}};
        foreach (t[i]) begin
            if (i == 5) begin
                checks++;
                if (b32.stall_cnt !== 32'd8) begin failures++; $display("FAIL dcache_stall got=%0d exp=8", b32.stall_cnt); end
            end
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL dcache[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if (b32.stall_cnt !== 32'd9) begin failures++; $display("FAIL dcache_same_cycle got=%0d exp=9", b32.stall_cnt); end
    endtask
    task automatic test_priority();
        cyc_t t [6] = '{{5'b11001, 3'd0, FRZ, 2'd0}, {5'b00011, 3'd1, FRZ, 2'd1},
                        {5'b00011, 3'd1, FRZ, 2'd1}, {5'b00111, 3'd1, FRZ, 2'd1},
                        {5'b00011, 3'd1, MIS, 2'd0}, {5'b00001, 3'd0, RUNV, 2'd0}};
        foreach (t[i]) begin
            if (i == 4) begin
                checks++;
                if (b32.flush_cnt !== 32'd2 || b32.loaduse_cnt !== 32'd2) begin
                    failures++; $display("FAIL priority_held got flush=%0d lu=%0d exp 2/2", b32.flush_cnt, b32.loaduse_cnt);
                end
            end
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL priority[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== {32'd13, 32'd3, 32'd2}) begin
            failures++; $display("FAIL priority_cnt got=%0d/%0d/%0d exp=13/3/2", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
    endtask
    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            apply({5'b00000, 3'd0, IC, 2'd0});
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL sat[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b3.stall_cnt, b3.flush_cnt, b3.loaduse_cnt} !== {3'd7, 3'd3, 3'd2}) begin
            failures++; $display("FAIL sat_cnt3 got=%0d/%0d/%0d exp=7/3/2", b3.stall_cnt, b3.flush_cnt, b3.loaduse_cnt);
        end
        checks++;
        if (b32.stall_cnt !== 32'd22) begin failures++; $display("FAIL sat_cnt32 got=%0d exp=22", b32.stall_cnt); end
    endtask
    task automatic test_reset_dwait();
        cyc_t t [3] = '{{5'b00001, 3'd0, RUNV, 2'd0}, {5'b00101, 3'd0, RUNV, 2'd0},
                        {5'b00001, 3'd0, RUNV, 2'd0}};
        apply({5'b11001, 3'd0, FRZ, 2'd0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL rdw_miss got=%b exp=%b", obs(), e); end
        @(negedge clk);
        apply({5'b00001, 3'd0, FRZ, 2'd1});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL rdw_wait got=%b exp=%b", obs(), e); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs() !== {RST, 2'd0}) begin failures++; $display("FAIL rdw_async got=%b exp=%b", obs(), {RST, 2'd0}); end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt, b3.stall_cnt, b3.flush_cnt, b3.loaduse_cnt} !== 105'd0) begin
            failures++; $display("FAIL rdw_cnt got=%0d/%0d/%0d/%0d exp=0", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt, b3.stall_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        foreach (t[i]) begin
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL rdw_after[%0d] got=%b exp=%b", i, obs(), e); end
            @(negedge clk);
        end
        checks++;
        if ({b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt} !== 96'd0) begin
            failures++; $display("FAIL rdw_after_cnt got=%0d/%0d/%0d exp=0/0/0", b32.stall_cnt, b32.flush_cnt, b32.loaduse_cnt);
        end
    endtask
    initial begin
        test_reset();
        test_loaduse();
        test_mispredict();
        test_dcache();
        test_priority();
        test_saturation();
        test_reset_dwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
